// File: rtl/ctrl_txn_profiler.sv
// ctrl_txn_profiler: timestamps the ap_ctrl start/done handshake of one HLS
// module instance and emits one latency/interval record per completed
// transaction on a valid/ready stream.
//
// Ports:
//   clock, reset                      single clock, synchronous active-high reset
//   ap_start, ap_ready, ap_done,      monitored block-level handshake
//   ap_continue
//   finish                            end of run; blocks further starts once seen
//   rec_valid/rec_ready               record stream handshake
//   rec_id, rec_start, rec_latency,   record payload (head of record FIFO)
//   rec_interval, rec_first
//   drop_count                        records lost to a full FIFO (saturating)
//   err_underflow, err_overflow       sticky protocol error flags
//   busy                              timestamp queue or record FIFO non-empty
module ctrl_txn_profiler #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned REC_DEPTH = 8,
  parameter int unsigned ID_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_start,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic             rec_first,
  output logic [CNT_W-1:0] drop_count,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic             busy
);

  localparam int unsigned TA_W = $clog2(OUT_DEPTH);
  localparam int unsigned TC_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned RA_W = $clog2(REC_DEPTH);
  localparam int unsigned RC_W = $clog2(REC_DEPTH + 1);

  typedef struct packed {
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] interval;
    logic             first;
  } ts_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] interval;
    logic             first;
  } rec_t;

  typedef enum logic {ARMED = 1'b0, WAIT_READY = 1'b1} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cyc, last_start;
  logic             first_q, fin_q;
  ts_t              ts_mem [OUT_DEPTH];
  logic [TA_W-1:0]  ts_rd, ts_wr;
  logic [TC_W-1:0]  ts_cnt, ts_cnt_nxt;
  rec_t             rec_mem [REC_DEPTH];
  logic [RA_W-1:0]  rec_rd, rec_wr;
  logic [RC_W-1:0]  rec_cnt, rec_cnt_nxt;
  logic [ID_W-1:0]  id_q;

  logic fin_seen, start_ev, done_ev;
  logic ts_push, ts_pop, rec_form, underflow, overflow;
  logic rec_pop, rec_push, rec_drop, rec_full, ts_empty, ts_full;
  ts_t  new_ent, src;
  rec_t new_rec;

  // Start FSM: a start is only recognised while ARMED; WAIT_READY ignores
  // ap_start until the module acknowledges with ap_ready.
  always_ff @(posedge clock) begin
    if (reset) state <= ARMED;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_ev   = 1'b0;
    fin_seen   = fin_q | finish;
    case (state)
      ARMED: begin
        if (ap_start && !fin_seen) begin
          start_ev = 1'b1;
          if (!ap_ready) next_state = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (ap_ready) next_state = ARMED;
      end
      default: next_state = ARMED;
    endcase
  end

  // Queue/FIFO control; a done on an empty queue may consume the same-cycle start.
  always_comb begin
    done_ev          = ap_done & ap_continue;
    new_ent.start    = cyc;
    new_ent.interval = first_q ? '0 : cyc - last_start;
    new_ent.first    = first_q;
    ts_empty         = (ts_cnt == '0);
    ts_full          = (ts_cnt == TC_W'(OUT_DEPTH));
    ts_push          = 1'b0;
    ts_pop           = 1'b0;
    rec_form         = 1'b0;
    underflow        = 1'b0;
    overflow         = 1'b0;
    src              = ts_mem[ts_rd];
    if (done_ev) begin
      if (!ts_empty) begin
        ts_pop   = 1'b1;
        ts_push  = start_ev;
        rec_form = 1'b1;
      end else if (start_ev) begin
        src      = new_ent;
        rec_form = 1'b1;
      end else begin
        underflow = 1'b1;
      end
    end else if (start_ev) begin
      if (ts_full) overflow = 1'b1;
      else         ts_push  = 1'b1;
    end
    new_rec.id       = id_q;
    new_rec.start    = src.start;
    new_rec.latency  = cyc - src.start;
    new_rec.interval = src.interval;
    new_rec.first    = src.first;
    rec_pop     = rec_valid & rec_ready;
    rec_full    = (rec_cnt == RC_W'(REC_DEPTH));
    rec_push    = rec_form & (~rec_full | rec_pop);
    rec_drop    = rec_form & rec_full & ~rec_pop;
    ts_cnt_nxt  = TC_W'(ts_cnt + TC_W'(ts_push) - TC_W'(ts_pop));
    rec_cnt_nxt = RC_W'(rec_cnt + RC_W'(rec_push) - RC_W'(rec_pop));
  end

  // Counters, queues, record FIFO and status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc           <= '0;
      last_start    <= '0;
      first_q       <= 1'b1;
      fin_q         <= 1'b0;
      ts_rd         <= '0;
      ts_wr         <= '0;
      ts_cnt        <= '0;
      rec_rd        <= '0;
      rec_wr        <= '0;
      rec_cnt       <= '0;
      id_q          <= '0;
      drop_count    <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      rec_valid     <= 1'b0;
      busy          <= 1'b0;
      for (int unsigned i = 0; i < OUT_DEPTH; i++) ts_mem[i] <= '0;
      for (int unsigned i = 0; i < REC_DEPTH; i++) rec_mem[i] <= '0;
    end else begin
      cyc   <= cyc + CNT_W'(1);
      fin_q <= fin_seen;
      if (start_ev) begin
        last_start <= cyc;
        first_q    <= 1'b0;
      end
      if (ts_push) begin
        ts_mem[ts_wr] <= new_ent;
        ts_wr         <= ts_wr + TA_W'(1);
      end
      if (ts_pop) ts_rd <= ts_rd + TA_W'(1);
      ts_cnt <= ts_cnt_nxt;
      if (rec_form) id_q <= id_q + ID_W'(1);
      if (rec_push) begin
        rec_mem[rec_wr] <= new_rec;
        rec_wr          <= rec_wr + RA_W'(1);
      end
      if (rec_pop) rec_rd <= rec_rd + RA_W'(1);
      rec_cnt <= rec_cnt_nxt;
      if (rec_drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
      if (underflow) err_underflow <= 1'b1;
      if (overflow)  err_overflow  <= 1'b1;
      rec_valid <= (rec_cnt_nxt != '0);
      busy      <= (ts_cnt_nxt != '0) || (rec_cnt_nxt != '0);
    end
  end

  // Payload is the FIFO head; it only moves on an accepted pop.
  always_comb begin
    rec_id       = rec_mem[rec_rd].id;
    rec_start    = rec_mem[rec_rd].start;
    rec_latency  = rec_mem[rec_rd].latency;
    rec_interval = rec_mem[rec_rd].interval;
    rec_first    = rec_mem[rec_rd].first;
  end

endmodule

// File: tb/tb_ctrl_txn_profiler.sv
// tb_ctrl_txn_profiler: directed scenarios plus randomized traffic for
// ctrl_txn_profiler, checked every cycle against a queue-based reference model.
module tb_ctrl_txn_profiler;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned OUT_DEPTH = 4;
  localparam int unsigned REC_DEPTH = 8;
  localparam int unsigned ID_W      = 16;
  localparam int unsigned CMASK     = (1 << CNT_W) - 1;
  localparam int unsigned IMASK     = (1 << ID_W) - 1;

  logic             clock = 1'b0;
  logic             reset, ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready;
  logic             rec_valid, rec_first, err_underflow, err_overflow, busy;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_start, rec_latency, rec_interval, drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_txn_profiler #(
    .CNT_W(CNT_W), .OUT_DEPTH(OUT_DEPTH), .REC_DEPTH(REC_DEPTH), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_start(rec_start), .rec_latency(rec_latency), .rec_interval(rec_interval),
    .rec_first(rec_first), .drop_count(drop_count), .err_underflow(err_underflow),
    .err_overflow(err_overflow), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned st;
    int unsigned iv;
    bit          fst;
  } ts_ent_t;

  typedef struct {
    int unsigned id;
    int unsigned st;
    int unsigned lat;
    int unsigned iv;
    bit          fst;
  } rec_ent_t;

  // Reference model state, updated from the spec's transaction rules.
  int unsigned m_cyc, m_last, m_id, m_drop;
  bit          m_armed, m_fin, m_first, m_uf, m_of;
  ts_ent_t     tsq[$];
  rec_ent_t    recq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit       fin_now, st_ev, dn_ev, pop, have;
    ts_ent_t  e, h;
    rec_ent_t r;
    if (reset) begin
      m_cyc = 0; m_last = 0; m_id = 0; m_drop = 0;
      m_armed = 1; m_fin = 0; m_first = 1; m_uf = 0; m_of = 0;
      tsq.delete(); recq.delete();
      return;
    end
    fin_now = m_fin | finish;
    st_ev   = m_armed && ap_start && !fin_now;
    dn_ev   = ap_done && ap_continue;
    pop     = (recq.size() > 0) && rec_ready;
    e.st    = m_cyc;
    e.iv    = m_first ? 0 : ((m_cyc - m_last) & CMASK);
    e.fst   = m_first;
    have    = 0;
    h       = e;
    if (dn_ev) begin
      if (tsq.size() > 0) begin
        h = tsq.pop_front();
        have = 1;
        if (st_ev) tsq.push_back(e);
      end else if (st_ev) begin
        have = 1;
      end else begin
        m_uf = 1;
      end
    end else if (st_ev) begin
      if (tsq.size() == OUT_DEPTH) m_of = 1;
      else tsq.push_back(e);
    end
    if (st_ev) begin
      m_last = m_cyc; m_first = 0; m_armed = ap_ready;
    end else if (!m_armed && ap_ready) begin
      m_armed = 1;
    end
    if (pop) void'(recq.pop_front());
    if (have) begin
      r.id = m_id; r.st = h.st; r.lat = (m_cyc - h.st) & CMASK; r.iv = h.iv; r.fst = h.fst;
      if (recq.size() < REC_DEPTH) recq.push_back(r);
      else if (m_drop != CMASK) m_drop++;
      m_id = (m_id + 1) & IMASK;
    end
    m_fin = fin_now;
    m_cyc = (m_cyc + 1) & CMASK;
  endtask

  task automatic compare();
    chk("rec_valid", rec_valid, recq.size() != 0);
    if (recq.size() != 0) begin
      chk("rec_id", rec_id, recq[0].id);
      chk("rec_start", rec_start, recq[0].st);
      chk("rec_latency", rec_latency, recq[0].lat);
      chk("rec_interval", rec_interval, recq[0].iv);
      chk("rec_first", rec_first, recq[0].fst);
    end
    chk("drop_count", drop_count, m_drop);
    chk("err_underflow", err_underflow, m_uf);
    chk("err_overflow", err_overflow, m_of);
    chk("busy", busy, (tsq.size() != 0) || (recq.size() != 0));
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    compare();
  endtask

  task automatic idle();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); step(); reset = 0;
  endtask

  // Advance with idle handshake until the next cycle has the given count.
  task automatic idle_to(input int unsigned c);
    int n = 0;
    idle();
    while (m_cyc != c && n < 600) begin step(); n++; end
    chk("idle_to_bound", m_cyc, c);
  endtask

  task automatic pulse(input bit s, input bit rdy, input bit d);
    ap_start = s; ap_ready = rdy; ap_done = d; ap_continue = d;
    step();
    idle();
  endtask

  initial begin
    idle(); rec_ready = 0; reset = 1;
    do_reset();
    chk("rst_valid", rec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);

    // Single transaction, then a second across the counter wrap.
    rec_ready = 1;
    idle_to(5);  pulse(1, 1, 0);
    idle_to(12); pulse(0, 0, 1);
    chk("t1_valid", rec_valid, 1);
    chk("t1_id", rec_id, 0);
    chk("t1_start", rec_start, 5);
    chk("t1_lat", rec_latency, 7);
    chk("t1_iv", rec_interval, 0);
    chk("t1_first", rec_first, 1);
    step();
    idle_to(250); pulse(1, 1, 0);
    idle_to(4);   pulse(0, 0, 1);
    chk("wrap_lat", rec_latency, 10);
    chk("wrap_iv", rec_interval, 245);
    chk("wrap_first", rec_first, 0);
    step();

    // Done with nothing pending, then same-cycle start/done from empty.
    pulse(0, 0, 1);
    chk("uf_flag", err_underflow, 1);
    chk("uf_valid", rec_valid, 0);
    pulse(1, 1, 1);
    chk("same_lat", rec_latency, 0);
    step();

    // Back-to-back starts and dones.
    do_reset();
    idle_to(10); pulse(1, 1, 0);
    idle_to(13); pulse(0, 0, 1);
    chk("b2b_lat0", rec_latency, 3);
    idle_to(14); pulse(1, 1, 0);
    idle_to(20); pulse(0, 0, 1);
    chk("b2b_lat1", rec_latency, 6);
    chk("b2b_iv1", rec_interval, 4);

    // Overlap: five starts into a four-entry queue.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(1, 1, 0);
      chk("of_flag", err_overflow, i == 4);
    end
    for (int i = 0; i < 4; i++) pulse(0, 0, 1);
    pulse(0, 0, 1);
    chk("of_fifth_unrecorded", err_underflow, 1);
    for (int i = 0; i < 6; i++) step();

    // Backpressure: ten completions into an eight-deep FIFO.
    do_reset();
    rec_ready = 0;
    for (int i = 0; i < 10; i++) begin pulse(1, 1, 0); pulse(0, 0, 1); end
    chk("bp_drop", drop_count, 2);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_order", rec_id, i);
      step();
    end
    chk("bp_busy", busy, 0);

    // Reset mid-transaction discards the pending start.
    do_reset();
    idle_to(18); pulse(1, 1, 0);
    idle_to(20); reset = 1; step(); reset = 0;
    chk("mid_rst_busy", busy, 0);
    pulse(0, 0, 1);
    chk("mid_rst_uf", err_underflow, 1);

    // Finish before any start blocks it.
    do_reset();
    finish = 1; step(); finish = 0;
    pulse(1, 1, 0);
    step();
    chk("fin_valid", rec_valid, 0);
    chk("fin_busy", busy, 0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      reset       = ($urandom_range(0, 499) == 0);
      finish      = ($urandom_range(0, 999) == 0);
      ap_start    = ($urandom_range(0, 1) == 0);
      ap_ready    = ($urandom_range(0, 9) < 4);
      ap_done     = ($urandom_range(0, 9) < 4);
      ap_continue = ($urandom_range(0, 9) < 8);
      rec_ready   = ((i / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
      step();
    end
    reset = 0; idle(); rec_ready = 1;
    for (int i = 0; i < 20; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
